// File: rtl/wb_irq_controller_if.sv
// Wishbone B3 register-slave bus bundle for the interrupt controller.
// Byte address, 32-bit data, byte selects; ack/err terminate a cycle.
interface wb_irq_controller_if;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_irq_controller.sv
// Programmable interrupt controller on a Wishbone register slave: per-source
// enable, edge/level mode, polarity, software set/clear and lowest-index ID.
module wb_irq_controller #(
  parameter int unsigned NUM_IRQ     = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] POL_RESET   = 32'hFFFF_FFFF
) (
  input  logic               clk_i,
  input  logic               nrst_i,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  wb_irq_controller_if.slave wb,
  output logic               irq_o
);

  localparam logic [31:0] IMPL_MASK = 32'hFFFF_FFFF >> (32 - NUM_IRQ);

  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_PENDING  = 3'd1,
    REG_ENABLE   = 3'd2,
    REG_MODE     = 3'd3,
    REG_POLARITY = 3'd4,
    REG_CLEAR    = 3'd5,
    REG_SET      = 3'd6,
    REG_ID       = 3'd7
  } reg_e;

  logic [31:0] sync_q [SYNC_STAGES];
  logic [31:0] edgePrev_q, edgePrev_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] enable_q, enable_d;
  logic [31:0] mode_q, mode_d;
  logic [31:0] polarity_q, polarity_d;
  logic [31:0] datOut_q, datOut_d;
  logic        ack_q, ack_d, err_q, err_d, irq_q, irq_d;

  reg_e        regSel;
  logic        req, wrAcc;
  logic [31:0] byteMask, wrData, clrMask, setMask, chgMask;
  logic [31:0] syncOut, active, rise, status, idVal, rdData;
  logic        unusedAdr;

  assign unusedAdr = ^wb.wb_adr_i[1:0];

  always_comb begin
    regSel   = reg_e'(wb.wb_adr_i[4:2]);
    req      = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
    err_d    = req & wb.wb_we_i & (regSel inside {REG_STATUS, REG_PENDING, REG_ID});
    ack_d    = req & ~err_d;
    wrAcc    = ack_d & wb.wb_we_i;
    byteMask = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
    wrData   = wb.wb_dat_i & byteMask & IMPL_MASK;

    enable_d   = enable_q;
    mode_d     = mode_q;
    polarity_d = polarity_q;
    if (wrAcc && regSel == REG_ENABLE)   enable_d   = (enable_q & ~byteMask) | wrData;
    if (wrAcc && regSel == REG_MODE)     mode_d     = (mode_q & ~byteMask) | wrData;
    if (wrAcc && regSel == REG_POLARITY) polarity_d = (polarity_q & ~byteMask) | wrData;
    clrMask = (wrAcc && regSel == REG_CLEAR) ? wrData : 32'd0;
    setMask = (wrAcc && regSel == REG_SET)   ? wrData : 32'd0;

    syncOut = sync_q[SYNC_STAGES-1];
    active  = ~(syncOut ^ polarity_q) & IMPL_MASK;
    rise    = active & ~edgePrev_q;

    // Reconfiguring a bit discards its pending state; the edge history takes
    // the post-write active value so the change itself never looks like an edge.
    chgMask    = (mode_d ^ mode_q) | (polarity_d ^ polarity_q);
    pending_d  = ((mode_q & ((pending_q & ~clrMask) | rise | setMask)) |
                  (~mode_q & active)) & ~chgMask & IMPL_MASK;
    edgePrev_d = ~(syncOut ^ polarity_d) & IMPL_MASK;

    status = pending_q & enable_q;
    idVal  = 32'd0;
    for (int i = 31; i >= 0; i--) begin
      if (status[i]) idVal = {1'b1, 26'd0, 5'(i)};
    end

    unique case (regSel)
      REG_STATUS:   rdData = status;
      REG_PENDING:  rdData = pending_q;
      REG_ENABLE:   rdData = enable_q;
      REG_MODE:     rdData = mode_q;
      REG_POLARITY: rdData = polarity_q;
      REG_ID:       rdData = idVal;
      default:      rdData = 32'd0;
    endcase
    datOut_d = (ack_d && !wb.wb_we_i) ? rdData : 32'd0;
    irq_d    = |status;
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= 32'd0;
      edgePrev_q <= 32'd0;
      pending_q  <= 32'd0;
      enable_q   <= 32'd0;
      mode_q     <= 32'd0;
      polarity_q <= POL_RESET & IMPL_MASK;
      datOut_q   <= 32'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      sync_q[0] <= 32'(irq_src_i);
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      edgePrev_q <= edgePrev_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      polarity_q <= polarity_d;
      datOut_q   <= datOut_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      irq_q      <= irq_d;
    end
  end

  assign wb.wb_dat_o = datOut_q;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;
  assign irq_o       = irq_q;

endmodule

// File: doc/wb_irq_controller.md
Name: wb_irq_controller

Overview:
Parametrised Wishbone B3 slave interrupt controller for the SoC. It replaces the hard-wired 32-bit interrupt vector fed to the CPU with a programmable block. The block supports per-source enable, edge/level mode, polarity, software set/clear and a lowest-index priority ID. It sits on the data bus as a 32-bit register slave and drives one combined irq_o into the CPU interrupt input.

Parameters:
NUM_IRQ, 32, number of interrupt sources (1..32); register bits [31:NUM_IRQ] read 0 and ignore writes
SYNC_STAGES, 2, synchroniser flops per source (>=2)
POL_RESET, 32'hFFFF_FFFF, reset value of POLARITY (1 = active-high)

Ports:
clk_i      in   1        system clock; all logic on rising edge
nrst_i     in   1        asynchronous, active-low reset
irq_src_i  in   NUM_IRQ  raw interrupt sources, asynchronous to clk_i
wb_adr_i   in   5        byte address; bits [4:2] select register, [1:0] ignored
wb_dat_i   in   32       write data
wb_sel_i   in   4        byte selects
wb_we_i    in   1        write enable
wb_cyc_i   in   1        cycle
wb_stb_i   in   1        strobe
wb_dat_o   out  32       read data, valid with ack
wb_ack_o   out  1        normal termination
wb_err_o   out  1        error termination
irq_o      out  1        combined interrupt to CPU

Behaviour:
- Reset (nrst_i low, asynchronous): sync flops, edge-history flops, PENDING, ENABLE, MODE = 0; POLARITY = POL_RESET; wb_ack_o, wb_err_o, wb_dat_o, irq_o = 0. Deassertion takes effect on the next clk_i edge.
- active[i] = sync[i] XNOR POLARITY[i].
- Register map (adr[4:2]):
  - 0 STATUS: RO, PENDING & ENABLE.
  - 1 PENDING: RO.
  - 2 ENABLE: RW.
  - 3 MODE: RW; 1 = edge, 0 = level.
  - 4 POLARITY: RW.
  - 5 CLEAR: WO, write-1-clears edge pending.
  - 6 SET: WO, write-1-sets edge pending.
  - 7 ID: RO, {valid, 26'b0, idx[4:0]}; idx is the lowest set bit of STATUS; all zero when STATUS == 0.
- Byte writes: wb_sel_i[n] gates byte n of RW registers and of the CLEAR/SET masks.
- Wishbone handshake:
  - cyc&stb&!ack&!err sampled high: exactly one of ack/err pulses for one cycle on the next edge.
  - ack/err deassert the following cycle, so back-to-back accesses take 2 cycles each.
  - Write data is committed on the same edge ack rises.
  - Read data is registered with ack and sampled from state before that edge.
  - Writes to STATUS, PENDING or ID give err instead of ack and change no state.
  - Reads of CLEAR or SET return 0 with ack.
  - cyc dropping mid-access cancels nothing: the pulse still occurs once.
- PENDING update, every cycle, per bit:
  - Edge mode: set on an active rising transition (active & ~active_prev), or on a SET write bit. Cleared by a CLEAR write bit. Simultaneous set and clear: set wins.
  - Level mode: PENDING[i] <= active[i]. CLEAR and SET are ignored.
- A write to MODE or POLARITY clears PENDING for every bit whose MODE or POLARITY value changed. The edge history flop is loaded with the new active value, so no spurious edge results.
- irq_o <= |(PENDING & ENABLE), registered.
- Latency: a source change reaches the synchroniser output after SYNC_STAGES edges, PENDING after +1, irq_o after +1, for SYNC_STAGES+2 clk_i edges total.
- ENABLE does not gate PENDING capture. A disabled edge interrupt stays latched and asserts irq_o once it is enabled.
- Glitches shorter than one clk_i period may be missed. Sources must be held for at least 1 period.
- Reset mid-transaction aborts it: no ack or err is produced.

Test Plan:
1. Reset -> all reads return 0 except POLARITY = 32'hFFFF_FFFF. irq_o = 0. Read of reg 5 gives ack with data 0.
2. Level mode: ENABLE=0x4, raise irq_src_i[2] -> irq_o high exactly 4 edges later (SYNC_STAGES=2). ID = 0x8000_0002. Drop the source -> irq_o low 4 edges later.
3. Edge mode on bit 5: pulse the source for 1 cycle -> PENDING=0x20 and stays set. Write CLEAR=0x20 in the same cycle as a new edge -> PENDING stays 0x20. CLEAR with no edge -> 0.
4. Priority: sources 3, 7 and 31 pending and enabled -> ID=0x8000_0003. Disable bit 3 -> ID=0x8000_0007.
5. Write STATUS -> wb_err_o pulses for 1 cycle, wb_ack_o stays 0, STATUS is unchanged. Write ENABLE with sel=4'b0010 and data 0xFFFF_FFFF -> ENABLE=0x0000_FF00.
6. Polarity flip on a held-high level source (POLARITY[0] 1->0) -> PENDING[0] clears on the write, then follows the new active level (source low => pending) with normal latency. No edge pending appears in edge mode.
